spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_ctrl_pkg.sv | 30 +++
 rtl/spi_ctrl_clkdiv.sv | 38 +++
 rtl/spi_controller.sv | 157 +++++++++++++++
 tb/tb_spi_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Purpose: shared types and constants for the SPI write/read frame controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: the state enum, frame field widths, write-direction encoding and
// the packed frame layout {rw, addr, wdata}, sent MSB first.
package spi_ctrl_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;

  // Value of frame bit 15 that marks a register write.
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } frame_t;

endpackage

// File: rtl/spi_ctrl_clkdiv.sv
// Purpose: half-period tick generator for the SPI clock.
// Latency: tick fires in the CLK_DIV-th cycle after enable rises, then every CLK_DIV cycles.
// Backpressure: none; the counter is held at zero while i_en is low.
//
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : count enable (controller is outside IDLE)
//   o_tick         : one-cycle strobe marking the last cycle of a half-period
module spi_ctrl_clkdiv #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  // 8 bits covers every legal divider value up to 255.
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en && w_last;

  // Counter restarts on every tick so each sclk edge reloads a full half-period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 8'd0;
    end else if (!i_en || w_last) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// Purpose: SPI mode-0 controller sending one 16-bit frame {rw, addr, wdata} per start.
// Latency: ncs falls the cycle after accept; done pulses 33*CLK_DIV+1 cycles after accept; idle again at 34*CLK_DIV+1.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, never queued.
//
// Ports:
//   i_clk, i_rst_n           : clock, async active-low reset
//   i_start                  : transaction request
//   i_rw, i_addr, i_wdata    : frame fields, latched in the accept cycle
//   o_sclk, o_copi, o_ncs    : SPI bus (sclk idles low, ncs active-low)
//   o_busy, o_done           : status; done is a single-cycle pulse at frame end
//   i_cipo, o_rdata          : readback path, present only with SPI_CONTROLLER_CIPO_EN
//
// Optional build macro: SPI_CONTROLLER_CIPO_EN adds the cipo sampler and rdata port.
module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
`ifdef SPI_CONTROLLER_CIPO_EN
  input  logic              i_cipo,
  output logic [DATA_W-1:0] o_rdata,
`endif
  output logic              o_sclk,
  output logic              o_copi,
  output logic              o_ncs,
  output logic              o_busy,
  output logic              o_done
);

  state_t                r_state;
  logic                  r_sclk;
  logic                  r_copi;
  logic                  r_ncs;
  logic                  r_busy;
  logic                  r_done;
  logic [3:0]            r_bit_cnt;
  // Only frame[14:0] is kept: bit 15 goes straight onto copi at accept.
  logic [FRAME_BITS-2:0] r_shift;
  frame_t                w_frame;
  logic                  w_tick;
  logic                  w_en;
`ifdef SPI_CONTROLLER_CIPO_EN
  logic [DATA_W-1:0]     r_rx;
  logic [DATA_W-1:0]     r_rdata;
`endif

  assign w_frame = '{rw: i_rw, addr: i_addr, wdata: i_wdata};
  assign w_en    = (r_state != ST_IDLE);

  spi_ctrl_clkdiv #(
    .CLK_DIV (CLK_DIV)
  ) u_clkdiv (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_en),
    .o_tick  (w_tick)
  );

  // Every tick is exactly one bus event: an sclk edge, the ncs release, or the end of the gap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_sclk    <= 1'b0;
      r_copi    <= 1'b0;
      r_ncs     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bit_cnt <= 4'd0;
      r_shift   <= '0;
`ifdef SPI_CONTROLLER_CIPO_EN
      r_rx      <= '0;
      r_rdata   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_shift   <= w_frame[FRAME_BITS-2:0];
            r_copi    <= w_frame.rw;
            r_ncs     <= 1'b0;
            r_sclk    <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_cnt <= 4'd0;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // First half-period is the copi setup time before rise 0.
          if (w_tick) begin
            r_sclk  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            if (r_sclk) begin
              // Falling edge: the only place copi is allowed to change.
              r_sclk <= 1'b0;
              if (r_bit_cnt == 4'd15) begin
                r_copi  <= 1'b0;
                r_state <= ST_HOLD;
              end else begin
                r_copi    <= r_shift[FRAME_BITS-2];
                r_shift   <= {r_shift[FRAME_BITS-3:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end else begin
              // Rising edge k occurs with r_bit_cnt == k.
              r_sclk <= 1'b1;
`ifdef SPI_CONTROLLER_CIPO_EN
              if (r_bit_cnt[3]) begin
                r_rx <= {r_rx[DATA_W-2:0], i_cipo};
              end
`endif
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_ncs   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_GAP;
`ifdef SPI_CONTROLLER_CIPO_EN
            r_rdata <= r_rx;
`endif
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_sclk = r_sclk;
  assign o_copi = r_copi;
  assign o_ncs  = r_ncs;
  assign o_busy = r_busy;
  assign o_done = r_done;
`ifdef SPI_CONTROLLER_CIPO_EN
  assign o_rdata = r_rdata;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Purpose: directed self-checking bench for spi_controller at CLK_DIV = 4, 2 and 255.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [2:0] w_sclk, w_copi, w_ncs, w_busy, w_done;
  logic [2:0] cipo_v;
  logic [7:0] rdata_a [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi_controller #(
      .CLK_DIV ((g == 0) ? 4 : (g == 1) ? 2 : 255)
    ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start_v[g]),
      .i_rw    (rw),
      .i_addr  (addr),
      .i_wdata (wdata),
`ifdef SPI_CONTROLLER_CIPO_EN
      .i_cipo  (cipo_v[g]),
      .o_rdata (rdata_a[g]),
`endif
      .o_sclk  (w_sclk[g]),
      .o_copi  (w_copi[g]),
      .o_ncs   (w_ncs[g]),
      .o_busy  (w_busy[g]),
      .o_done  (w_done[g])
    );
  end

`ifndef SPI_CONTROLLER_CIPO_EN
  initial begin
    rdata_a[0] = 8'h00;
    rdata_a[1] = 8'h00;
    rdata_a[2] = 8'h00;
  end
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-frame observation results, filled by run_frame.
  int          e_sclk, e_copi, e_ncs, e_busy, e_done, e_tog, rises;
  logic [15:0] rise_bits;
  logic [7:0]  obs_rdata;
  logic [15:0] cipo_pat = 16'h0000;

  // Write-only register peripheral on the CLK_DIV=4 bus: captures 16 bits, commits writes on ncs rise.
  logic [7:0]  pm_regs [128];
  logic [15:0] pm_sh  = 16'h0000;
  int          pm_cnt = 0;
  initial foreach (pm_regs[i]) pm_regs[i] = 8'h00;
  always @(negedge w_ncs[0]) begin
    pm_cnt = 0;
    pm_sh  = 16'h0000;
  end
  always @(posedge w_sclk[0]) begin
    if (!w_ncs[0]) begin
      pm_sh  = {pm_sh[14:0], w_copi[0]};
      pm_cnt = pm_cnt + 1;
    end
  end
  always @(posedge w_ncs[0]) begin
    if (pm_cnt == 16 && pm_sh[15]) pm_regs[pm_sh[14:8]] = pm_sh[7:0];
  end

  // Requests one frame on DUT sel (caller is at a negedge) and samples every cycle
  // T0+1..T0+34*cd+1 against the cycle-exact timing expected for that divider.
  task automatic run_frame(input int sel, input int cd, input bit hold, input int pulse_at);
    logic [15:0] f;
    int          p;
    logic        s_exp, c_exp, n_exp, b_exp, d_exp, prev_s;
    f = {rw, addr, wdata};
    e_sclk = 0; e_copi = 0; e_ncs = 0; e_busy = 0; e_done = 0; e_tog = 0; rises = 0;
    rise_bits = 16'h0000; obs_rdata = 8'h00; prev_s = 1'b0;
    start_v[sel] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 34 * cd + 1; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) start_v[sel] = 1'b0;
      if (pulse_at != 0 && c == pulse_at) start_v[sel] = 1'b1;
      if (pulse_at != 0 && c == pulse_at + 1) start_v[sel] = 1'b0;
      p     = (c - 1) / cd;
      s_exp = (c <= 32 * cd) && (p % 2 == 1);
      n_exp = !(c <= 33 * cd);
      d_exp = (c == 33 * cd + 1);
      b_exp = (c <= 34 * cd);
      c_exp = (p < 32) ? f[15 - p / 2] : 1'b0;
      if (w_sclk[sel] !== s_exp) e_sclk++;
      if (w_copi[sel] !== c_exp) e_copi++;
      if (w_ncs[sel]  !== n_exp) e_ncs++;
      if (w_busy[sel] !== b_exp) e_busy++;
      if (w_done[sel] !== d_exp) e_done++;
      if (w_sclk[sel] === 1'b1 && w_ncs[sel] === 1'b1) e_tog++;
      if (w_sclk[sel] === 1'b1 && prev_s === 1'b0) begin
        rises++;
        rise_bits = {rise_bits[14:0], w_copi[sel]};
      end
      prev_s = w_sclk[sel];
      if (d_exp) obs_rdata = rdata_a[sel];
      // Present the bit for the next rise while sclk is low.
      cipo_v[sel] = ((p + 1) / 2 <= 15) ? cipo_pat[15 - (p + 1) / 2] : 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_v = 3'b000; rw = 1'b0; addr = 7'h00; wdata = 8'h00; cipo_v = 3'b000;
    repeat (3) @(negedge clk);
    tests_run++; if (w_sclk !== 3'b000) begin tests_failed++; $display("FAIL reset_sclk got %b want 000", w_sclk); end
    tests_run++; if (w_copi !== 3'b000) begin tests_failed++; $display("FAIL reset_copi got %b want 000", w_copi); end
    tests_run++; if (w_ncs  !== 3'b111) begin tests_failed++; $display("FAIL reset_ncs got %b want 111", w_ncs); end
    tests_run++; if (w_busy !== 3'b000) begin tests_failed++; $display("FAIL reset_busy got %b want 000", w_busy); end
    tests_run++; if (w_done !== 3'b000) begin tests_failed++; $display("FAIL reset_done got %b want 000", w_done); end
    tests_run++; if (rdata_a[0] !== 8'h00) begin tests_failed++; $display("FAIL reset_rdata got %h want 00", rdata_a[0]); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (w_ncs !== 3'b111 || w_busy !== 3'b000) begin tests_failed++; $display("FAIL idle_after_reset ncs %b busy %b want 111/000", w_ncs, w_busy); end
  endtask

  task automatic test_write_f0;
    rw = 1'b1; addr = 7'h00; wdata = 8'hF0;
    run_frame(0, 4, 1'b0, 0);
    tests_run++; if (e_sclk !== 0) begin tests_failed++; $display("FAIL f0_sclk_timing got %0d bad cycles want 0", e_sclk); end
    tests_run++; if (e_copi !== 0) begin tests_failed++; $display("FAIL f0_copi got %0d bad cycles want 0", e_copi); end
    tests_run++; if (e_ncs  !== 0) begin tests_failed++; $display("FAIL f0_ncs got %0d bad cycles want 0", e_ncs); end
    tests_run++; if (e_busy !== 0) begin tests_failed++; $display("FAIL f0_busy got %0d bad cycles want 0", e_busy); end
    tests_run++; if (e_done !== 0) begin tests_failed++; $display("FAIL f0_done got %0d bad cycles want 0", e_done); end
    tests_run++; if (e_tog  !== 0) begin tests_failed++; $display("FAIL f0_sclk_ncs_high got %0d want 0", e_tog); end
    tests_run++; if (rises !== 16) begin tests_failed++; $display("FAIL f0_rises got %0d want 16", rises); end
    tests_run++; if (rise_bits !== 16'h80F0) begin tests_failed++; $display("FAIL f0_bits got %h want 80f0", rise_bits); end
  endtask

  task automatic test_peripheral;
    rw = 1'b1; addr = 7'h04; wdata = 8'h80;
    run_frame(0, 4, 1'b0, 0);
    tests_run++; if (pm_regs[4] !== 8'h80) begin tests_failed++; $display("FAIL periph_duty got %h want 80", pm_regs[4]); end
    rw = 1'b0; addr = 7'h05; wdata = 8'h33;
    run_frame(0, 4, 1'b0, 0);
    tests_run++; if (pm_regs[5] !== 8'h00) begin tests_failed++; $display("FAIL periph_read_no_write got %h want 00", pm_regs[5]); end
    tests_run++; if (rise_bits !== 16'h0533) begin tests_failed++; $display("FAIL periph_read_bits got %h want 0533", rise_bits); end
  endtask

  task automatic test_back_to_back;
    int bad;
    rw = 1'b1; addr = 7'h12; wdata = 8'h34;
    run_frame(0, 4, 1'b1, 0);
    tests_run++; if (e_busy !== 0 || e_ncs !== 0) begin tests_failed++; $display("FAIL b2b_first busy %0d ncs %0d bad cycles want 0", e_busy, e_ncs); end
    // Start is still high: the next frame must be accepted at this very cycle (T0+137).
    rw = 1'b0; addr = 7'h55; wdata = 8'hAA;
    run_frame(0, 4, 1'b0, 0);
    tests_run++; if (e_sclk + e_copi + e_ncs + e_busy + e_done !== 0) begin tests_failed++; $display("FAIL b2b_second_timing got %0d bad cycles want 0", e_sclk + e_copi + e_ncs + e_busy + e_done); end
    tests_run++; if (rise_bits !== 16'h55AA) begin tests_failed++; $display("FAIL b2b_second_bits got %h want 55aa", rise_bits); end
    rw = 1'b1; addr = 7'h01; wdata = 8'h02;
    run_frame(0, 4, 1'b0, 40);
    tests_run++; if (e_ncs + e_busy + e_done !== 0) begin tests_failed++; $display("FAIL pulse_frame got %0d bad cycles want 0", e_ncs + e_busy + e_done); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (w_busy[0] !== 1'b0 || w_ncs[0] !== 1'b1) bad++;
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL pulse_ignored got %0d busy cycles want 0", bad); end
  endtask

  task automatic test_reset_mid;
    int dones;
    rw = 1'b1; addr = 7'h2A; wdata = 8'hC3;
    start_v[0] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1) start_v[0] = 1'b0;
    end
    tests_run++; if (w_ncs[0] !== 1'b0) begin tests_failed++; $display("FAIL mid_frame_active ncs got %b want 0", w_ncs[0]); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (w_ncs[0] !== 1'b1 || w_sclk[0] !== 1'b0 || w_busy[0] !== 1'b0 || w_copi[0] !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset ncs %b sclk %b busy %b copi %b want 1/0/0/0", w_ncs[0], w_sclk[0], w_busy[0], w_copi[0]);
    end
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (w_done[0] !== 1'b0) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (w_done[0] !== 1'b0 || w_busy[0] !== 1'b0) dones++;
    end
    tests_run++; if (dones !== 0) begin tests_failed++; $display("FAIL mid_reset_no_done got %0d activity cycles want 0", dones); end
    rw = 1'b0; addr = 7'h6B; wdata = 8'h5E;
    run_frame(0, 4, 1'b0, 0);
    tests_run++; if (e_sclk + e_copi + e_ncs + e_busy + e_done !== 0) begin tests_failed++; $display("FAIL post_reset_frame got %0d bad cycles want 0", e_sclk + e_copi + e_ncs + e_busy + e_done); end
    tests_run++; if (rise_bits !== 16'h6B5E) begin tests_failed++; $display("FAIL post_reset_bits got %h want 6b5e", rise_bits); end
  endtask

  task automatic test_clkdiv_range;
    int errs, bad_rises, bad_bits;
    logic [15:0] f;
    for (int d = 1; d <= 2; d++) begin
      errs = 0; bad_rises = 0; bad_bits = 0;
      for (int n = 0; n < ((d == 1) ? 10 : 2); n++) begin
        rw    = 1'($urandom_range(0, 1));
        addr  = 7'($urandom_range(0, 127));
        wdata = 8'($urandom_range(0, 255));
        f = {rw, addr, wdata};
        run_frame(d, (d == 1) ? 2 : 255, 1'b0, 0);
        errs = errs + e_sclk + e_copi + e_ncs + e_busy + e_done + e_tog;
        if (rises != 16) bad_rises++;
        if (rise_bits !== f) bad_bits++;
      end
      tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL div_timing dut%0d got %0d bad cycles want 0", d, errs); end
      tests_run++; if (bad_rises !== 0) begin tests_failed++; $display("FAIL div_rises dut%0d got %0d bad frames want 0", d, bad_rises); end
      tests_run++; if (bad_bits !== 0) begin tests_failed++; $display("FAIL div_bits dut%0d got %0d bad frames want 0", d, bad_bits); end
    end
  endtask

`ifdef SPI_CONTROLLER_CIPO_EN
  task automatic test_cipo;
    cipo_pat = 16'h00A5;
    rw = 1'b0; addr = 7'h10; wdata = 8'h00;
    run_frame(0, 4, 1'b0, 0);
    cipo_pat = 16'h0000;
    tests_run++; if (obs_rdata !== 8'hA5) begin tests_failed++; $display("FAIL cipo_rdata got %h want a5", obs_rdata); end
  endtask
`endif

  initial begin
    test_reset;
    test_write_f0;
    test_peripheral;
    test_back_to_back;
    test_reset_mid;
    test_clkdiv_range;
`ifdef SPI_CONTROLLER_CIPO_EN
    test_cipo;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
